// File: rtl/shift_sched_pkg.sv
// shift_sched_pkg: shared types and constants for the shift scheduler.
//   - sh_mode_e : shift/rotate mode encodings
//   - s1_t      : request held in the first pipeline stage
//   - CNT_W     : width of the optional per-requester grant counters
// The s1_t field widths come from the SS_* constants. Change these
// constants, not only the top-level parameters, when resizing the block.
package shift_sched_pkg;

    localparam int SS_DSIZE = 64;
    localparam int SS_ASIZE = 6;
    localparam int SS_IDW   = 2;
    localparam int CNT_W    = 16;

    typedef enum logic [1:0] {
        SH_SHL  = 2'b00,
        SH_SHR  = 2'b01,
        SH_ROTL = 2'b10,
        SH_ROTR = 2'b11
    } sh_mode_e;

    typedef struct packed {
        logic [SS_DSIZE-1:0] data;
        logic [SS_ASIZE-1:0] amount;
        sh_mode_e            mode;
        logic [SS_IDW-1:0]   id;
    } s1_t;

endpackage

// File: rtl/shift_sched_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i   : per-requester valid
//   ptr_i   : highest-priority index for this cycle
//   en_i    : when low, nothing is granted
//   grant_o : one-hot grant, or zero
//   idx_o   : encoded index of the granted requester (0 when no grant)
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o
);

    logic found;
    int   j;

    // Scan ptr, ptr+1, ... modulo NREQ; first valid requester wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (en_i && !found && req_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/shift_sched.sv
// shift_sched: round-robin scheduler sharing one barrel shifter among
// NREQ requesters. Two-stage pipeline: S1 holds the granted request,
// S2 holds the registered result.
//   clk, rst          : clock, asynchronous active-high reset
//   req_valid_i/ready_o, req_data_i, req_amount_i, req_mode_i : requests
//   out_valid_o/ready_i, out_data_o, out_id_o                 : results
// Optional (macro SHIFT_SCHED_CNT_EN): per-requester 16-bit saturating
// grant counters with cnt_sel_i, cnt_clr_i inputs and cnt_value_o output.
module shift_sched
    import shift_sched_pkg::*;
#(
    parameter int DSIZE = SS_DSIZE,
    parameter int ASIZE = SS_ASIZE,
    parameter int NREQ  = 4,
    parameter int IDW   = SS_IDW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ*DSIZE-1:0] req_data_i,
    input  logic [NREQ*ASIZE-1:0] req_amount_i,
    input  logic [NREQ*2-1:0]     req_mode_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DSIZE-1:0]      out_data_o,
    output logic [IDW-1:0]        out_id_o
`ifdef SHIFT_SCHED_CNT_EN
    ,
    input  logic [IDW-1:0]        cnt_sel_i,
    input  logic                  cnt_clr_i,
    output logic [CNT_W-1:0]      cnt_value_o
`endif
);

    s1_t             s1_q, s1_d;
    logic            s1_v_q;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            out_valid_q;
    logic [DSIZE-1:0] out_data_q;
    logic [IDW-1:0]  out_id_q;

    logic            s2_load, s1_free, any_grant;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  idx;

    // Rotates take the matching half of the doubled operand, so an
    // amount of zero returns the input without a special case.
    function automatic logic [DSIZE-1:0] shift_op(
        input logic [DSIZE-1:0] in,
        input logic [ASIZE-1:0] a,
        input sh_mode_e         m
    );
        logic [2*DSIZE-1:0] rl, rr;
        rl = {in, in} << a;
        rr = {in, in} >> a;
        case (m)
            SH_SHL:  shift_op = in << a;
            SH_SHR:  shift_op = in >> a;
            SH_ROTL: shift_op = rl[2*DSIZE-1:DSIZE];
            default: shift_op = rr[DSIZE-1:0];
        endcase
    endfunction

    assign s2_load = s1_v_q & (~out_valid_q | out_ready_i);
    assign s1_free = ~s1_v_q | s2_load;

    // Gating with rst keeps req_ready low while reset is held.
    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .en_i    (s1_free & ~rst),
        .grant_o (grant),
        .idx_o   (idx)
    );

    assign any_grant   = |grant;
    assign req_ready_o = grant;

    always_comb begin
        s1_d.data   = req_data_i[int'(idx)*DSIZE +: DSIZE];
        s1_d.amount = req_amount_i[int'(idx)*ASIZE +: ASIZE];
        s1_d.mode   = sh_mode_e'(req_mode_i[int'(idx)*2 +: 2]);
        s1_d.id     = idx;
        ptr_d       = (idx == IDW'(NREQ-1)) ? '0 : idx + IDW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= '0;
            s1_v_q      <= 1'b0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            if (s2_load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= shift_op(s1_q.data, s1_q.amount, s1_q.mode);
                out_id_q    <= s1_q.id;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            if (s1_free) begin
                s1_v_q <= any_grant;
                if (any_grant) begin
                    s1_q  <= s1_d;
                    ptr_q <= ptr_d;
                end
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_id_o    = out_id_q;

`ifdef SHIFT_SCHED_CNT_EN
    logic [NREQ-1:0][CNT_W-1:0] cnt_q;

    // Clear wins over a same-cycle grant; counts saturate at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_clr_i) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign cnt_value_o = (int'(cnt_sel_i) < NREQ) ? cnt_q[cnt_sel_i] : '0;
`endif

endmodule
